// File: rtl/slicer_phase_ctrl.sv
// Symbol-phase scheduler ahead of slicer_pam4: finds the phase with the lowest PAM4 decision error, then feeds it.
// Optional SLICER_RELOCK_EN: keep tracking the locked phase's error and re-search when a window sum exceeds RELOCK_THR.
module slicer_phase_ctrl #(
    parameter int NB         = 8,
    parameter int NF         = 7,
    parameter int OS         = 4,
    parameter int LOG2_WIN   = 4,
    parameter int RELOCK_THR = 256,
    localparam int PH_W      = (OS > 1) ? $clog2(OS) : 1,
    localparam int EW        = NF - 1,
    localparam int AW        = NF - 1 + LOG2_WIN
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic signed [NB-1:0] i_sample,
    input  logic                 i_start,
    output logic                 o_slc_enable,
    output logic                 o_slc_valid,
    output logic        [NB-1:0] o_slc_sample,
    output logic      [PH_W-1:0] o_phase,
    output logic                 o_locked,
    output logic                 o_busy,
    output logic        [AW-1:0] o_err_min
);

    typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, LOCK} state_t;

    localparam logic signed [NB+1:0] LVL_HI  = (NB+2)'(3 * (2 ** (NF-2)));
    localparam logic signed [NB+1:0] LVL_LO  = (NB+2)'(2 ** (NF-2));
    localparam logic signed [NB+1:0] THR_MID = (NB+2)'(2 ** (NF-1));
    localparam logic      [PH_W-1:0] PH_LAST = PH_W'(OS-1);

    // Distance to the nearest PAM4 level; a sample exactly on a threshold belongs to the level above.
    function automatic logic [EW-1:0] slice_err(input logic signed [NB-1:0] s);
        logic signed [NB+1:0] x;
        logic signed [NB+1:0] d;
        x = {{2{s[NB-1]}}, s};
        if (x >= THR_MID)       d = x - LVL_HI;
        else if (!x[NB+1])      d = x - LVL_LO;
        else if (x >= -THR_MID) d = x + LVL_LO;
        else                    d = x + LVL_HI;
        if (d[NB+1]) d = -d;
        return d[EW-1:0];
    endfunction

    state_t                state, state_nxt;
    logic                  clr_win;
    logic                  adv, win_open, win_last, slc_fire;
    logic       [PH_W-1:0] ph_cnt, scan_idx, best_idx, cand_idx;
    logic   [LOG2_WIN-1:0] sym_cnt;
    logic                  armed;
    logic         [AW-1:0] acc [OS];
    logic         [AW-1:0] best_val, cand_val;
    logic         [EW-1:0] e_cur;
    logic                  slc_vld_p1;
`ifdef SLICER_RELOCK_EN
    logic         [AW-1:0] lock_acc, lock_sum;
    logic                  lock_end;
`endif

    assign adv      = i_enable & i_valid;
    assign e_cur    = slice_err(i_sample);
    assign win_open = armed | (ph_cnt == '0);
    assign win_last = win_open & (ph_cnt == PH_LAST) & (sym_cnt == '1);
    assign slc_fire = adv & (state == LOCK) & (state_nxt == LOCK) & (ph_cnt == o_phase);
    assign o_slc_valid = slc_vld_p1 & i_enable;

`ifdef SLICER_RELOCK_EN
    assign lock_sum = lock_acc + ((ph_cnt == o_phase) ? {{LOG2_WIN{1'b0}}, e_cur} : '0);
    assign lock_end = adv & (state == LOCK) & win_last;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        clr_win      = 1'b0;
        o_locked     = (state == LOCK);
        o_slc_enable = (state == LOCK);
        o_busy       = (state == MEASURE) || (state == DECIDE);
        if (i_start) begin
            state_nxt = MEASURE;
            clr_win   = 1'b1;
        end else if (i_enable) begin
            case (state)
                MEASURE: if (adv && win_last) state_nxt = DECIDE;
                DECIDE: if (scan_idx == PH_LAST) begin
                    state_nxt = LOCK;
                    clr_win   = 1'b1;
                end
`ifdef SLICER_RELOCK_EN
                LOCK: if (lock_end && (int'(lock_sum) > RELOCK_THR)) begin
                    state_nxt = MEASURE;
                    clr_win   = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)  ph_cnt <= '0;
        else if (adv) ph_cnt <= (ph_cnt == PH_LAST) ? '0 : ph_cnt + PH_W'(1);
    end

    // Window bookkeeping: aligned to the first phase-0 advance after (re)entry.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset || clr_win) begin
            armed   <= 1'b0;
            sym_cnt <= '0;
            for (int p = 0; p < OS; p++) acc[p] <= '0;
`ifdef SLICER_RELOCK_EN
            lock_acc <= '0;
`endif
        end else if (adv && win_open && (state == MEASURE)) begin
            armed       <= 1'b1;
            acc[ph_cnt] <= acc[ph_cnt] + {{LOG2_WIN{1'b0}}, e_cur};
            if (ph_cnt == PH_LAST) sym_cnt <= sym_cnt + LOG2_WIN'(1);
`ifdef SLICER_RELOCK_EN
        end else if (adv && win_open && (state == LOCK)) begin
            armed    <= 1'b1;
            lock_acc <= win_last ? '0 : lock_sum;
            if (ph_cnt == PH_LAST) sym_cnt <= sym_cnt + LOG2_WIN'(1);
`endif
        end
    end

    always_comb begin
        cand_val = best_val;
        cand_idx = best_idx;
        if ((scan_idx == '0) || (acc[scan_idx] < best_val)) begin
            cand_val = acc[scan_idx];
            cand_idx = scan_idx;
        end
    end

    // Decision scan: one accumulator per enabled cycle, result published on the last.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            scan_idx  <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            o_phase   <= '0;
            o_err_min <= '0;
        end else if (i_start) begin
            scan_idx <= '0;
        end else if (i_enable && (state == DECIDE)) begin
            if (scan_idx == PH_LAST) begin
                o_phase   <= cand_idx;
                o_err_min <= cand_val;
                scan_idx  <= '0;
            end else begin
                best_val <= cand_val;
                best_idx <= cand_idx;
                scan_idx <= scan_idx + PH_W'(1);
            end
`ifdef SLICER_RELOCK_EN
        end else if (lock_end) begin
            o_err_min <= lock_sum;
`endif
        end
    end

    // Slicer feed, one register stage.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            slc_vld_p1   <= 1'b0;
            o_slc_sample <= '0;
        end else begin
            slc_vld_p1 <= slc_fire;
            if (slc_fire) o_slc_sample <= i_sample;
        end
    end

endmodule

// File: tb/tb_slicer_phase_ctrl.sv
// Directed bench for slicer_phase_ctrl (OS=4, WIN=16, NB=8, NF=7); honours SLICER_RELOCK_EN for the relock case.
module tb_slicer_phase_ctrl;

    logic              i_clock = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_enable = 1'b0;
    logic              i_valid = 1'b0;
    logic signed [7:0] i_sample = '0;
    logic              i_start = 1'b0;
    logic              o_slc_enable, o_slc_valid, o_locked, o_busy;
    logic        [7:0] o_slc_sample;
    logic        [1:0] o_phase;
    logic        [9:0] o_err_min;

    slicer_phase_ctrl dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_sample(i_sample), .i_start(i_start), .o_slc_enable(o_slc_enable),
        .o_slc_valid(o_slc_valid), .o_slc_sample(o_slc_sample), .o_phase(o_phase),
        .o_locked(o_locked), .o_busy(o_busy), .o_err_min(o_err_min)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic signed [7:0] s;
        int                err;
    } vec_t;

    int                pass_cnt = 0;
    int                total_cnt = 0;
    logic        [1:0] tb_ph = 2'd0;
    int                tb_sym = 0;
    int                mode = 0;
    logic        [1:0] best_ph = 2'd2;
    logic signed [7:0] const_val = '0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // mode 0: best_ph carries exact levels, others 64; mode 1: every sample 5 off a level; mode 2: constant.
    function automatic logic signed [7:0] gen();
        logic signed [7:0] v;
        v = const_val;
        if (mode == 0) begin
            if (tb_ph != best_ph) v = 8'sd64;
            else case (tb_sym % 4)
                0: v = 8'sd96;
                1: v = 8'sd32;
                2: v = -8'sd32;
                default: v = -8'sd96;
            endcase
        end else if (mode == 1) begin
            case (tb_sym % 4)
                0: v = 8'sd101;
                1: v = 8'sd27;
                2: v = -8'sd27;
                default: v = -8'sd91;
            endcase
        end
        return v;
    endfunction

    task automatic step(input logic v, input logic en, input logic st);
        i_valid  = v;
        i_enable = en;
        i_start  = st;
        i_sample = gen();
        @(posedge i_clock);
        if (en && v) begin
            if (tb_ph == 2'd3) begin
                tb_ph = 2'd0;
                tb_sym++;
            end else begin
                tb_ph = tb_ph + 2'd1;
            end
        end
        @(negedge i_clock);
        i_start = 1'b0;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!o_locked && n < 400) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        check("lock_reached", int'(o_locked), 1);
    endtask

    vec_t              tbl[10];
    int                n2, n4, dv, bad;
    logic              exp_v;
    logic signed [7:0] exp_s;

    initial begin
        tbl[0] = '{8'sd64, 512};
        tbl[1] = '{8'sd63, 496};
        tbl[2] = '{8'sd0, 512};
        tbl[3] = '{-8'sd1, 496};
        tbl[4] = '{-8'sd64, 512};
        tbl[5] = '{-8'sd65, 496};
        tbl[6] = '{8'sd127, 496};
        tbl[7] = '{-8'sd128, 512};
        tbl[8] = '{8'sd96, 0};
        tbl[9] = '{8'sd100, 64};

        repeat (3) @(negedge i_clock);
        check("reset_outputs", int'({o_slc_enable, o_slc_valid, o_locked, o_busy, o_phase, o_slc_sample, o_err_min}), 0);
        i_reset = 1'b0;
        repeat (12) step(1'b1, 1'b1, 1'b0);
        check("idle_no_start", int'({o_locked, o_busy, o_slc_valid}), 0);

        // exact levels on phase 2
        mode = 0;
        best_ph = 2'd2;
        step(1'b1, 1'b1, 1'b1);
        check("busy_after_start", int'(o_busy), 1);
        wait_lock(n2);
        check("t2_phase", int'(o_phase), 2);
        check("t2_err_min", int'(o_err_min), 0);
        check("t2_slc_enable", int'(o_slc_enable), 1);
        check("t2_busy_off", int'(o_busy), 0);
        dv = 0;
        for (int k = 0; k < 20; k++) begin
            exp_v = (tb_ph == 2'd2);
            exp_s = gen();
            step(1'b1, 1'b1, 1'b0);
            dv += int'(o_slc_valid);
            check("slc_valid", int'(o_slc_valid), int'(exp_v));
            if (exp_v) check("slc_sample", int'($signed(o_slc_sample)), int'(exp_s));
        end
        check("slc_valid_count", dv, 5);

        // gaps in i_valid and i_enable during the measurement
        step(1'b1, 1'b1, 1'b1);
        n4 = 1;
        for (int k = 0; k < 30; k++) begin
            step(k[0] == 1'b0, 1'b1, 1'b0);
            n4++;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b0);
            n4++;
            bad += int'(o_slc_valid) + int'(!o_busy);
        end
        check("t4_frozen", bad, 0);
        wait_lock(dv);
        n4 += dv;
        check("t4_phase", int'(o_phase), 2);
        check("t4_err_min", int'(o_err_min), 0);
        check("t4_lock_later", int'(n4 > n2 + 20), 1);

        // restart while locked, stream moved to phase 1
        best_ph = 2'd1;
        step(1'b1, 1'b1, 1'b1);
        check("t5_locked_drop", int'(o_locked), 0);
        check("t5_slc_enable_drop", int'(o_slc_enable), 0);
        check("t5_phase_hold", int'(o_phase), 2);
        wait_lock(dv);
        check("t5_phase", int'(o_phase), 1);
        check("t5_err_min", int'(o_err_min), 0);

        // locked link degrades to all-64 samples
        mode = 2;
        const_val = 8'sd64;
`ifdef SLICER_RELOCK_EN
        dv = 0;
        while (o_locked && dv < 200) begin
            step(1'b1, 1'b1, 1'b0);
            dv++;
        end
        check("t6_relock_drop", int'(o_locked), 0);
        check("t6_relock_busy", int'(o_busy), 1);
        check("t6_err_over_thr", int'(int'(o_err_min) > 256), 1);
`else
        repeat (150) step(1'b1, 1'b1, 1'b0);
        check("t6_stays_locked", int'(o_locked), 1);
        check("t6_err_frozen", int'(o_err_min), 0);
`endif

        // all phases identical: lowest index wins
        mode = 1;
        step(1'b1, 1'b1, 1'b1);
        wait_lock(dv);
        check("t3_tie_phase", int'(o_phase), 0);
        check("t3_tie_err", int'(o_err_min), 80);

        mode = 2;
        for (int i = 0; i < 10; i++) begin
            const_val = tbl[i].s;
            step(1'b1, 1'b1, 1'b1);
            wait_lock(dv);
            check("vec_phase", int'(o_phase), 0);
            check("vec_err_min", int'(o_err_min), tbl[i].err);
        end

        // asynchronous reset while locked
        mode = 0;
        best_ph = 2'd2;
        step(1'b1, 1'b1, 1'b1);
        wait_lock(dv);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        check("pre_reset_phase", int'(o_phase), 2);
        #2 i_reset = 1'b1;
        #1 check("async_reset", int'({o_slc_enable, o_slc_valid, o_locked, o_busy, o_phase, o_slc_sample, o_err_min}), 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        tb_ph = 2'd0;
        tb_sym = 0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 1'b1, 1'b0);
            bad += int'(o_slc_valid) + int'(o_locked) + int'(o_busy);
        end
        check("post_reset_quiet", bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
